seq_pattern_gen: RTL

Serial pattern generator: drives a programmable WIDTH-bit pattern out one bit per clock, MSB first, and repeats it a programmed number of times with an optional idle gap between repetitions. It is the transmit end of the serial sequence-detection path. Its `out` bit feeds the `in` pin of the non-overlapping Moore 1011 sequence detector. It is used as the stimulus source in system benches and as a self-test pattern source on the serial line. All outputs are registered (Moore style).

---
 rtl/seq_pattern_gen_if.sv | 26 ++
 rtl/seq_pattern_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen_if.sv
// Serial pattern generator control/data bundle.
// The master drives the controls and the slave drives the serial line.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             pat_we;
    logic [WIDTH-1:0] pat_in;
    logic [CNT_W-1:0] reps;
    logic             abort;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pat_we, pat_in, reps, abort,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pat_we, pat_in, reps, abort,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a WIDTH-bit pattern out MSB first,
// repeated reps times with GAP idle cycles between repetitions.
module seq_pattern_gen #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(4'b1011),
    parameter int               CNT_W       = 4,
    parameter int               GAP         = 0
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_gen_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             active;

    assign active = (state_q == S_SHIFT) || (state_q == S_GAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= DEFAULT_PAT;
            shreg_q <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        // A write in the start cycle is visible to the load below.
        if (bus.pat_we && !active) begin
            pat_d = bus.pat_in;
        end
        unique case (state_q)
            S_IDLE: begin
                if (!bus.abort && bus.start) begin
                    state_d = S_SHIFT;
                    shreg_d = pat_d;
                    bit_d   = '0;
                    rep_d   = (bus.reps == '0) ? CNT_W'(1) : bus.reps;
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bit_q == BW'(WIDTH - 1)) begin
                    rep_d = rep_q - CNT_W'(1);
                    bit_d = '0;
                    if (rep_q > CNT_W'(1)) begin
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            shreg_d = pat_q;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + BW'(1);
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == GW'(GAP - 1)) begin
                    state_d = S_SHIFT;
                    shreg_d = pat_q;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            S_SHIFT: begin
                out_d   = shreg_d[WIDTH-1];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
